// File: rtl/register_file_sb.sv
// register_file_sb: XLEN x 2**AW register file, 2 comb reads, 1 sync write,
// per-register busy scoreboard with registered busy count for RAW stalls.
// Ports: clk, rst (async high), en (state freeze), addr_1/addr_2 ->
// out_buf_1/out_buf_2 + busy_1/busy_2, we/addr_3/inp_buf_3 write,
// rsv/rsv_addr reservation, busy_cnt (AW+1 bits).
// Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read forwarding.
module register_file_sb #(
  parameter int XLEN    = 32,
  parameter int AW      = 5,
  parameter int ZERO_R0 = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [AW-1:0]   addr_1,
  input  logic [AW-1:0]   addr_2,
  output logic [XLEN-1:0] out_buf_1,
  output logic [XLEN-1:0] out_buf_2,
  output logic            busy_1,
  output logic            busy_2,
  input  logic            we,
  input  logic [AW-1:0]   addr_3,
  input  logic [XLEN-1:0] inp_buf_3,
  input  logic            rsv,
  input  logic [AW-1:0]   rsv_addr,
  output logic [AW:0]     busy_cnt
);

  localparam int   NREG = 2 ** AW;
  localparam logic Z0   = (ZERO_R0 != 0);

  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_n;
  logic [NREG-1:0] set_v;
  logic [NREG-1:0] clr_v;
  logic [AW:0]     cnt;
  logic [AW:0]     cnt_n;
  logic            wr_ok;
  logic            rsv_ok;
  logic            inc;
  logic            dec;

  function automatic logic is_zero(
    input logic [AW-1:0] a
  );
    return Z0 && (a == '0);
  endfunction

  // Register 0 (when hardwired) swallows writes and reservations.
  assign wr_ok  = en & we & ~is_zero(addr_3);
  assign rsv_ok = en & rsv & ~is_zero(rsv_addr);

  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (rsv_ok) set_v[rsv_addr] = 1'b1;
    if (wr_ok)  clr_v[addr_3]   = 1'b1;
  end

  // Set after clear: a reservation in the same edge as the
  // write to that register belongs to the newer producer.
  assign busy_n = (busy & ~clr_v) | set_v;

  // Counter tracks bit transitions only, so re-reserving a
  // busy register or writing an idle one leaves it alone.
  assign inc = rsv_ok & ~busy[rsv_addr];
  assign dec = wr_ok & busy[addr_3]
             & ~(rsv_ok & (rsv_addr == addr_3));

  assign cnt_n = cnt
               + {{AW{1'b0}}, inc}
               - {{AW{1'b0}}, dec};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
      busy <= '0;
      cnt  <= '0;
    end else if (en) begin
      if (wr_ok) mem[addr_3] <= inp_buf_3;
      busy <= busy_n;
      cnt  <= cnt_n;
    end
  end

  assign busy_cnt = cnt;

  always_comb begin
    out_buf_1 = mem[addr_1];
    busy_1    = busy[addr_1];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (addr_1 == addr_3)) begin
      out_buf_1 = inp_buf_3;
      busy_1    = rsv_ok && (rsv_addr == addr_1);
    end
`endif
    if (is_zero(addr_1)) begin
      out_buf_1 = '0;
      busy_1    = 1'b0;
    end
  end

  always_comb begin
    out_buf_2 = mem[addr_2];
    busy_2    = busy[addr_2];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (addr_2 == addr_3)) begin
      out_buf_2 = inp_buf_3;
      busy_2    = rsv_ok && (rsv_addr == addr_2);
    end
`endif
    if (is_zero(addr_2)) begin
      out_buf_2 = '0;
      busy_2    = 1'b0;
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: directed + random checks of register_file_sb
// against an array-based reference model.
module tb_register_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [4:0]  addr_1;
  logic [4:0]  addr_2;
  logic [31:0] out_buf_1;
  logic [31:0] out_buf_2;
  logic        busy_1;
  logic        busy_2;
  logic        we;
  logic [4:0]  addr_3;
  logic [31:0] inp_buf_3;
  logic        rsv;
  logic [4:0]  rsv_addr;
  logic [5:0]  busy_cnt;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_mem [32];
  logic        m_busy [32];

  register_file_sb #(
    .XLEN(32), .AW(5), .ZERO_R0(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .addr_1(addr_1), .addr_2(addr_2),
    .out_buf_1(out_buf_1), .out_buf_2(out_buf_2),
    .busy_1(busy_1), .busy_2(busy_2),
    .we(we), .addr_3(addr_3), .inp_buf_3(inp_buf_3),
    .rsv(rsv), .rsv_addr(rsv_addr),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (en && we && a == addr_3) return inp_buf_3;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_bz(input logic [4:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (en && we && a == addr_3)
      return rsv && rsv_addr == a;
`endif
    return m_busy[a];
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".rd1"}, 64'(out_buf_1), 64'(exp_rd(addr_1)));
    check({tag, ".rd2"}, 64'(out_buf_2), 64'(exp_rd(addr_2)));
    check({tag, ".bz1"}, 64'(busy_1), 64'(exp_bz(addr_1)));
    check({tag, ".bz2"}, 64'(busy_2), 64'(exp_bz(addr_2)));
    check({tag, ".cnt"}, 64'(busy_cnt), 64'(exp_cnt()));
  endtask

  // Apply the edge to the model, then let the DUT see it.
  task automatic tick();
    if (!rst && en) begin
      if (we && addr_3 != 0) begin
        m_mem[addr_3]  = inp_buf_3;
        m_busy[addr_3] = 1'b0;
      end
      if (rsv && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; rsv = 0; en = 1;
  endtask

  initial begin
    rst = 1; en = 0; we = 0; rsv = 0;
    addr_1 = 0; addr_2 = 1; addr_3 = 0;
    rsv_addr = 0; inp_buf_3 = 0;
    model_reset();
    #12;
    rst = 0;
    #1;
    check("rst.rd1", 64'(out_buf_1), 64'h0);
    check("rst.rd2", 64'(out_buf_2), 64'h0);
    check("rst.bz1", 64'(busy_1), 64'h0);
    check("rst.bz2", 64'(busy_2), 64'h0);
    check("rst.cnt", 64'(busy_cnt), 64'h0);

    // basic write, then frozen write
    en = 1; we = 1; addr_3 = 2; inp_buf_3 = 32'hdeadbeef;
    tick();
    idle(); addr_1 = 2; #1;
    check("wr.rd1", 64'(out_buf_1), 64'hdeadbeef);
    en = 0; we = 1; inp_buf_3 = 32'h12345678;
    tick();
    idle(); #1;
    check("en0.rd1", 64'(out_buf_1), 64'hdeadbeef);

    // zero register
    we = 1; addr_3 = 0; inp_buf_3 = 32'hfeefdeed;
    rsv = 1; rsv_addr = 0;
    tick();
    idle(); addr_1 = 0; #1;
    check("z.rd1", 64'(out_buf_1), 64'h0);
    check("z.bz1", 64'(busy_1), 64'h0);
    check("z.cnt", 64'(busy_cnt), 64'h0);

    // scoreboard
    rsv = 1; rsv_addr = 3; tick();
    rsv_addr = 5; tick();
    rsv = 1; rsv_addr = 5; tick();
    idle(); addr_1 = 3; #1;
    check("sb.cnt2", 64'(busy_cnt), 64'd2);
    check("sb.bz3", 64'(busy_1), 64'h1);
    we = 1; addr_3 = 3; inp_buf_3 = 32'h33; tick();
    idle(); #1;
    check("sb.cnt1", 64'(busy_cnt), 64'd1);
    check("sb.bz3c", 64'(busy_1), 64'h0);
    check("sb.rd3", 64'(out_buf_1), 64'h33);
    we = 1; addr_3 = 5; inp_buf_3 = 32'h0000_00aa;
    rsv = 1; rsv_addr = 5; tick();
    idle(); addr_2 = 5; #1;
    check("sb.bz5", 64'(busy_2), 64'h1);
    check("sb.rd5", 64'(out_buf_2), 64'haa);
    check("sb.cntsame", 64'(busy_cnt), 64'd1);
    we = 1; addr_3 = 9; inp_buf_3 = 32'h99; tick();
    idle(); addr_1 = 9; #1;
    check("sb.idlewr", 64'(busy_1), 64'h0);
    check("sb.idlecnt", 64'(busy_cnt), 64'd1);
    check_all("sb");

    // async reset mid-write
    rsv = 1; rsv_addr = 6; tick();
    idle();
    we = 1; addr_3 = 4; inp_buf_3 = 32'hcafef00d;
    @(negedge clk);
    #3;
    rst = 1;
    model_reset();
    #1;
    check("ar.cnt_hold", 64'(busy_cnt), 64'h0);
    @(posedge clk);
    #1;
    rst = 0; idle();
    addr_1 = 4; addr_2 = 6; #1;
    check("ar.rd4", 64'(out_buf_1), 64'h0);
    check("ar.bz6", 64'(busy_2), 64'h0);
    check("ar.cnt", 64'(busy_cnt), 64'h0);

    // forwarding (or its absence)
    we = 1; addr_3 = 7; inp_buf_3 = 32'h11111111; tick();
    idle(); addr_1 = 7;
    we = 1; addr_3 = 7; inp_buf_3 = 32'h0badf00d; #1;
`ifdef REGFILE_BYPASS_EN
    check("byp.same", 64'(out_buf_1), 64'h0badf00d);
`else
    check("byp.same", 64'(out_buf_1), 64'h11111111);
`endif
    tick();
    idle(); #1;
    check("byp.next", 64'(out_buf_1), 64'h0badf00d);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 7) != 0);
      we        = $urandom_range(0, 1);
      rsv       = $urandom_range(0, 1);
      addr_3    = 5'($urandom_range(0, 11));
      rsv_addr  = 5'($urandom_range(0, 11));
      addr_1    = 5'($urandom_range(0, 11));
      addr_2    = 5'($urandom);
      inp_buf_3 = $urandom;
      #1;
      check_all("rnd");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
